// File: rtl/keypad_scanner_if.sv
// Signal bundle between the keypad scanner, the keypad matrix/scan clock source
// and the downstream code-entry logic.
interface keypad_scanner_if;
  logic       scan_clk;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  scan_clk,
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output scan_clk,
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scanner.sv
// 4x4 keypad scanner: column stepping on synchronized scan ticks, debounce and key events.
// Define KEYPAD_REPEAT_EN to add auto-repeat pulses while an accepted key stays held.
module keypad_scanner #(
  parameter int unsigned DEBOUNCE_TICKS = 4,
  parameter int unsigned RELEASE_TICKS  = 2,
  parameter int unsigned REPEAT_TICKS   = 200
) (
  input  logic             clk,
  input  logic             rst,
  keypad_scanner_if.master kp
);

  typedef enum logic [1:0] {
    ST_SCAN    = 2'd0,
    ST_CONFIRM = 2'd1,
    ST_HELD    = 2'd2
  } state_t;

  localparam logic [7:0] DEB_LIM = 8'(DEBOUNCE_TICKS);
  localparam logic [7:0] REL_LIM = 8'(RELEASE_TICKS);
  localparam logic [7:0] REP_LIM = 8'(REPEAT_TICKS);

  logic       scan_s1_q, scan_s2_q, scan_s3_q;
  logic       tick_q;
  logic [3:0] row_s1_q, row_s2_q;

  state_t     state_q, state_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [7:0] cnt_q, cnt_d;
  logic [3:0] cand_pat_q, cand_pat_d;
  logic [3:0] cand_code_q, cand_code_d;
  logic [3:0] key_code_q, key_code_d;
  logic       key_valid_q, key_valid_d;
  logic       key_held_q, key_held_d;

  logic       rows_idle;
  logic [7:0] cnt_inc;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // Lowest active row index wins when several rows are pulled low together.
  function automatic logic [3:0] key_lookup(input logic [3:0] rows, input logic [1:0] c);
    logic [1:0] r;
    logic [3:0] code;
    if (!rows[0])      r = 2'd0;
    else if (!rows[1]) r = 2'd1;
    else if (!rows[2]) r = 2'd2;
    else               r = 2'd3;
    case ({r, c})
      4'h0:    code = 4'h1;
      4'h1:    code = 4'h2;
      4'h2:    code = 4'h3;
      4'h3:    code = 4'hA;
      4'h4:    code = 4'h4;
      4'h5:    code = 4'h5;
      4'h6:    code = 4'h6;
      4'h7:    code = 4'hB;
      4'h8:    code = 4'h7;
      4'h9:    code = 4'h8;
      4'hA:    code = 4'h9;
      4'hB:    code = 4'hC;
      4'hC:    code = 4'h0;
      4'hD:    code = 4'hF;
      4'hE:    code = 4'hE;
      4'hF:    code = 4'hD;
      default: code = 4'h0;
    endcase
    return code;
  endfunction

  // scan_clk is only ever sampled; its synchronized rising edge becomes a one-cycle tick.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      scan_s1_q <= 1'b0;
      scan_s2_q <= 1'b0;
      scan_s3_q <= 1'b0;
      tick_q    <= 1'b0;
      row_s1_q  <= 4'h0;
      row_s2_q  <= 4'h0;
    end else begin
      scan_s1_q <= kp.scan_clk;
      scan_s2_q <= scan_s1_q;
      scan_s3_q <= scan_s2_q;
      tick_q    <= scan_s2_q & ~scan_s3_q;
      row_s1_q  <= kp.row;
      row_s2_q  <= row_s1_q;
    end
  end

  assign rows_idle = &row_s2_q;
  assign cnt_inc   = sat_inc(cnt_q);

`ifdef KEYPAD_REPEAT_EN
  logic [7:0] rep_cnt_q, rep_cnt_d;
  logic [7:0] rep_inc;

  assign rep_inc = sat_inc(rep_cnt_q);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) rep_cnt_q <= 8'h00;
    else      rep_cnt_q <= rep_cnt_d;
  end
`else
  logic unused_rep;
  assign unused_rep = ^REP_LIM;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_SCAN;
      col_idx_q   <= 2'd0;
      cnt_q       <= 8'h00;
      cand_pat_q  <= 4'h0;
      cand_code_q <= 4'h0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      col_idx_q   <= col_idx_d;
      cnt_q       <= cnt_d;
      cand_pat_q  <= cand_pat_d;
      cand_code_q <= cand_code_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    col_idx_d   = col_idx_q;
    cnt_d       = cnt_q;
    cand_pat_d  = cand_pat_q;
    cand_code_d = cand_code_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    key_held_d  = key_held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_cnt_d   = rep_cnt_q;
`endif

    case (state_q)
      ST_SCAN: begin
        if (tick_q) begin
          if (rows_idle) begin
            col_idx_d = col_idx_q + 2'd1;
          end else begin
            cand_pat_d  = row_s2_q;
            cand_code_d = key_lookup(row_s2_q, col_idx_q);
            cnt_d       = 8'h00;
            state_d     = ST_CONFIRM;
          end
        end
      end

      ST_CONFIRM: begin
        if (tick_q) begin
          if (row_s2_q == cand_pat_q) begin
            if (cnt_inc >= DEB_LIM) begin
              key_code_d  = cand_code_q;
              key_valid_d = 1'b1;
              key_held_d  = 1'b1;
              cnt_d       = 8'h00;
`ifdef KEYPAD_REPEAT_EN
              rep_cnt_d   = 8'h00;
`endif
              state_d     = ST_HELD;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d     = 8'h00;
            col_idx_d = col_idx_q + 2'd1;
            state_d   = ST_SCAN;
          end
        end
      end

      ST_HELD: begin
        if (tick_q) begin
          if (rows_idle) begin
`ifdef KEYPAD_REPEAT_EN
            rep_cnt_d = 8'h00;
`endif
            if (cnt_inc >= REL_LIM) begin
              key_held_d = 1'b0;
              cnt_d      = 8'h00;
              col_idx_d  = col_idx_q + 2'd1;
              state_d    = ST_SCAN;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            cnt_d = 8'h00;
`ifdef KEYPAD_REPEAT_EN
            if (rep_inc >= REP_LIM) begin
              key_valid_d = 1'b1;
              rep_cnt_d   = 8'h00;
            end else begin
              rep_cnt_d = rep_inc;
            end
`endif
          end
        end
      end

      default: begin
        state_d = ST_SCAN;
        cnt_d   = 8'h00;
      end
    endcase
  end

  assign kp.col       = ~(4'b0001 << col_idx_q);
  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = key_held_q;

endmodule
